demux_3output: RTL and testbench

DEMUX_3OUTPUT -- requirements
Module: demux_3output

---
 rtl/demux_3output.sv | 134 +++++++++++++
 tb/tb_demux_3output.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_3output.sv
// demux_3output: one-entry holding stage that routes each accepted word to
// one of three output channels and counts completed transfers per channel.
//
// Ports
//   clk                      single clock, rising edge
//   rst                      asynchronous active-low reset
//   in, sel, in_valid        incoming word, destination select, valid
//   in_ready                 combinational: stage empty or being drained
//   out1..out3               held word (all three share one register)
//   out_valid1..out_valid3   held word is destined for that channel
//   out_ready1..out_ready3   consumer of that channel accepts
//   cnt1..cnt3               completed transfers per channel, mod 256
module demux_3output #(
   parameter int unsigned WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WORD_LENGTH-1:0] in,
   input  logic [1:0]             sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WORD_LENGTH-1:0] out1,
   output logic [WORD_LENGTH-1:0] out2,
   output logic [WORD_LENGTH-1:0] out3,
   output logic                   out_valid1,
   output logic                   out_valid2,
   output logic                   out_valid3,
   input  logic                   out_ready1,
   input  logic                   out_ready2,
   input  logic                   out_ready3,
   output logic [7:0]             cnt1,
   output logic [7:0]             cnt2,
   output logic [7:0]             cnt3
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      CH1 = 2'd0,
      CH2 = 2'd1,
      CH3 = 2'd2
   } dest_e;

   // Holding stage state
   logic                   full_q, full_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   dest_e                  dest_q, dest_d;
   logic [CNT_W-1:0]       cnt1_q, cnt1_d;
   logic [CNT_W-1:0]       cnt2_q, cnt2_d;
   logic [CNT_W-1:0]       cnt3_q, cnt3_d;

   logic consume_c;
   logic accept_c;

   // sel 2 and 3 both land on channel 3
   function automatic dest_e map_sel(input logic [1:0] s);
      dest_e d;
      case (s)
         2'd0:    d = CH1;
         2'd1:    d = CH2;
         default: d = CH3;
      endcase
      return d;
   endfunction

   // Handshake: only the ready of the addressed channel can drain the stage
   always_comb begin
      consume_c = 1'b0;
      case (dest_q)
         CH1:     consume_c = full_q & out_ready1;
         CH2:     consume_c = full_q & out_ready2;
         default: consume_c = full_q & out_ready3;
      endcase
      in_ready = ~full_q | consume_c;
      accept_c = in_valid & in_ready;
   end

   // Next-state: accept wins over drain so back-to-back words flow at full rate
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      dest_d = dest_q;
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      cnt3_d = cnt3_q;

      if (accept_c) begin
         full_d = 1'b1;
         data_d = in;
         dest_d = map_sel(sel);
      end else if (consume_c) begin
         full_d = 1'b0;
      end

      if (consume_c) begin
         case (dest_q)
            CH1:     cnt1_d = cnt1_q + CNT_W'(1);
            CH2:     cnt2_d = cnt2_q + CNT_W'(1);
            default: cnt3_d = cnt3_q + CNT_W'(1);
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         data_q <= '0;
         dest_q <= CH1;
         cnt1_q <= '0;
         cnt2_q <= '0;
         cnt3_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         dest_q <= dest_d;
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
         cnt3_q <= cnt3_d;
      end
   end

   // Outputs are decoded purely from registered state
   assign out1       = data_q;
   assign out2       = data_q;
   assign out3       = data_q;
   assign out_valid1 = full_q & (dest_q == CH1);
   assign out_valid2 = full_q & (dest_q == CH2);
   assign out_valid3 = full_q & (dest_q == CH3);
   assign cnt1       = cnt1_q;
   assign cnt2       = cnt2_q;
   assign cnt3       = cnt3_q;

endmodule

// File: tb/tb_demux_3output.sv
// Scoreboard bench for demux_3output: the driver keeps a behavioural model of
// the one-word stage and pushes every accepted word; an independent monitor
// pops and compares whenever the DUT completes a transfer.
module tb_demux_3output;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in;
   logic [1:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out1, out2, out3;
   logic        out_valid1, out_valid2, out_valid3;
   logic        out_ready1, out_ready2, out_ready3;
   logic [7:0]  cnt1, cnt2, cnt3;

   demux_3output #(.WORD_LENGTH(32)) dut (
      .clk(clk), .rst(rst), .in(in), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .out1(out1), .out2(out2), .out3(out3),
      .out_valid1(out_valid1), .out_valid2(out_valid2), .out_valid3(out_valid3),
      .out_ready1(out_ready1), .out_ready2(out_ready2), .out_ready3(out_ready3),
      .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [31:0] d;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model: channel index 0..2, counts kept as plain integers
   bit          m_full = 0;
   int          m_ch   = 0;
   logic [31:0] m_data = '0;
   int          m_cnt[3] = '{0, 0, 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_full = 0;
      m_ch   = 0;
      m_data = '0;
      m_cnt  = '{0, 0, 0};
      q.delete();
   endtask

   // One clock of stimulus: drive after negedge, check, then advance model at posedge
   task automatic cycle(input bit iv, input logic [1:0] s, input logic [31:0] d,
                        input bit r1, input bit r2, input bit r3);
      bit rdy[3];
      bit cons, acc, exp_rdy, live;
      @(negedge clk);
      in_valid = iv; sel = s; in = d;
      out_ready1 = r1; out_ready2 = r2; out_ready3 = r3;
      #1;
      live    = (rst === 1'b1);
      rdy     = '{r1, r2, r3};
      cons    = live && m_full && rdy[m_ch];
      exp_rdy = !m_full || cons;
      check("in_ready",   32'(in_ready),   32'(exp_rdy));
      check("out_valid1", 32'(out_valid1), 32'(m_full && m_ch == 0));
      check("out_valid2", 32'(out_valid2), 32'(m_full && m_ch == 1));
      check("out_valid3", 32'(out_valid3), 32'(m_full && m_ch == 2));
      if (m_full) begin
         check("out1", out1, m_data);
         check("out2", out2, m_data);
         check("out3", out3, m_data);
      end
      check("cnt1", 32'(cnt1), 32'(m_cnt[0]));
      check("cnt2", 32'(cnt2), 32'(m_cnt[1]));
      check("cnt3", 32'(cnt3), 32'(m_cnt[2]));
      acc = live && iv && exp_rdy;
      @(posedge clk);
      if (cons) m_cnt[m_ch] = (m_cnt[m_ch] + 1) % 256;
      if (acc) begin
         m_data = d;
         m_ch   = (s > 2'd2) ? 2 : int'(s);
         q.push_back('{m_ch, d});
      end
      m_full = acc ? 1'b1 : (cons ? 1'b0 : m_full);
   endtask

   // Assert reset between edges and check it takes effect without a clock
   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      model_clear();
      check("rst_valid1", 32'(out_valid1), 32'd0);
      check("rst_valid2", 32'(out_valid2), 32'd0);
      check("rst_valid3", 32'(out_valid3), 32'd0);
      check("rst_ready",  32'(in_ready),   32'd1);
      check("rst_out1",   out1,            32'd0);
      check("rst_cnt1",   32'(cnt1),       32'd0);
      check("rst_cnt2",   32'(cnt2),       32'd0);
      check("rst_cnt3",   32'(cnt3),       32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   // Monitor: every completed transfer must match the oldest accepted word
   initial begin
      int          ch;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         #3;
         if (rst === 1'b1) begin
            check("onehot", 32'(int'(out_valid1) + int'(out_valid2) + int'(out_valid3) <= 1), 32'd1);
            ch = -1;
            if (out_valid1 && out_ready1) begin ch = 0; d = out1; end
            if (out_valid2 && out_ready2) begin ch = 1; d = out2; end
            if (out_valid3 && out_ready3) begin ch = 2; d = out3; end
            if (ch >= 0) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL mon_unexpected: channel %0d presented %0h with nothing expected", ch + 1, d);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  check("mon_channel", 32'(ch), 32'(e.ch));
                  check("mon_data",    d,       e.d);
               end
            end
         end
      end
   end

   initial begin
      // Reset held with a word offered: nothing may be taken
      rst = 1'b0; in_valid = 1'b1; in = 32'hDEADBEEF; sel = 2'd0;
      out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
      #1;
      check("init_valid1", 32'(out_valid1), 32'd0);
      check("init_ready",  32'(in_ready),   32'd1);
      check("init_cnt1",   32'(cnt1),       32'd0);
      cycle(1, 2'd0, 32'hDEADBEEF, 1, 1, 1);
      cycle(1, 2'd0, 32'hDEADBEEF, 1, 1, 1);
      #2;
      rst = 1'b1;
      cycle(1, 2'd0, 32'hDEADBEEF, 0, 1, 1);
      cycle(0, 2'd0, 32'h0, 1, 1, 1);

      // Routing across all three channels
      async_reset();
      cycle(1, 2'd0, 32'h11, 1, 1, 1);
      cycle(1, 2'd1, 32'h22, 1, 1, 1);
      cycle(1, 2'd3, 32'h33, 1, 1, 1);
      cycle(0, 2'd0, 32'h0, 1, 1, 1);
      #1;
      check("route_cnt1", 32'(cnt1), 32'd1);
      check("route_cnt2", 32'(cnt2), 32'd1);
      check("route_cnt3", 32'(cnt3), 32'd1);

      // Backpressure on channel 2 while input keeps changing
      async_reset();
      cycle(1, 2'd1, 32'hA5A5A5A5, 1, 0, 1);
      for (int i = 0; i < 5; i++)
         cycle(1, 2'($urandom_range(3)), $urandom, 1, 0, 1);
      check("bp_hold", out2, 32'hA5A5A5A5);
      cycle(0, 2'd0, 32'h0, 1, 1, 1);
      #1;
      check("bp_cnt2", 32'(cnt2), 32'd1);

      // Only the addressed channel's ready counts
      cycle(1, 2'd0, 32'h0BADF00D, 1, 1, 1);
      cycle(1, 2'd2, 32'h12345678, 0, 1, 1);
      cycle(1, 2'd2, 32'h12345678, 0, 1, 1);
      cycle(0, 2'd0, 32'h0, 1, 0, 0);

      // Sustained one-word-per-cycle flow with counter wrap
      async_reset();
      for (int i = 0; i < 300; i++)
         cycle(1, 2'd2, $urandom, 0, 0, 1);
      cycle(0, 2'd0, 32'h0, 0, 0, 1);
      #1;
      check("wrap_cnt3", 32'(cnt3), 32'd44);

      // Reset while a word is held for channel 2
      async_reset();
      cycle(1, 2'd1, 32'hCAFE0002, 1, 0, 1);
      cycle(0, 2'd0, 32'h0, 1, 0, 1);
      async_reset();
      check("midhold_cnt2", 32'(cnt2), 32'd0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(9) < 7, 2'($urandom_range(3)), $urandom,
               $urandom_range(9) < 6, $urandom_range(9) < 6, $urandom_range(9) < 6);

      // Drain and confirm every accepted word came out
      repeat (3) cycle(0, 2'd0, 32'h0, 1, 1, 1);
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
